// File: rtl/hazard_ctrl.sv
// IF/ID + PC sequencing: squash-and-replay on load-use hazards, timed IF/ID clear
// after EX redirects, and saturating replay/redirect counters.
module hazard_ctrl #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [XLEN-1:0]  id_pc,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_redirect,
   input  logic [XLEN-1:0]  ex_target,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic [XLEN-1:0]  replay_pc,
   output logic             if_id_write,
   output logic             id_ex_flush,
   output logic [CNT_W-1:0] replay_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       fcnt_q, fcnt_d;
   logic [CNT_W-1:0] replay_cnt_q, replay_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             hz;

   // ex_target is consumed by the PC mux; only the select is produced here.
   logic             unused_target;
   assign unused_target = ^ex_target;

   assign hz = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      state_d      = state_q;
      fcnt_d       = fcnt_q;
      replay_cnt_d = replay_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      pc_write     = 1'b1;
      pc_sel       = 2'd0;
      replay_pc    = '0;
      if_id_write  = 1'b1;
      id_ex_flush  = 1'b0;

      if (rst) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else if (ex_redirect) begin
         // Redirect wins in either state; a same-cycle hazard is moot since ID is squashed.
         pc_sel      = 2'd1;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
         flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
         if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_RELOAD;
         end else begin
            state_d = RUN;
            fcnt_d  = 4'd0;
         end
      end else if (state_q == FLUSH) begin
         if_id_write = 1'b0;
         fcnt_d      = fcnt_q - 4'd1;
         if (fcnt_q <= 4'd1) begin
            state_d = RUN;
            fcnt_d  = 4'd0;
         end
      end else if (hz) begin
         // IF/ID cannot hold, so the consumer is squashed and refetched from its own PC.
         pc_sel       = 2'd2;
         replay_pc    = id_pc;
         if_id_write  = 1'b0;
         id_ex_flush  = 1'b1;
         replay_cnt_d = (replay_cnt_q == '1) ? replay_cnt_q : replay_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         fcnt_q       <= 4'd0;
         replay_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         fcnt_q       <= fcnt_d;
         replay_cnt_q <= replay_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign replay_cnt = replay_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule
